reaction_timer: RTL and testbench

Measures the interval between the stimulus event (end of the random pre-delay, i.e. the timed pulse that lights the stimulus LED) and the player's response button, in units of an external tick enable (1 ms in the meter). It is the measuring end of the stimulus/response path: the pre-delay timer produces the stimulus, and this block counts until the response arrives. It detects false starts (response before stimulus) and saturates on overflow. The result drives the BCD conversion/display path.

---
 rtl/reaction_timer.sv | 125 ++++++++++++
 tb/tb_reaction_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction timer: counts ticks from stimulus (start) to response, flags false starts.
// Optional REACTION_TIMER_RESP_SYNC_EN adds a 2-flop synchroniser on resp.
module reaction_timer #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             start,
    input  logic             tick,
    input  logic             resp,
    output logic [WIDTH-1:0] elapsed,
    output logic             valid,
    output logic             overflow,
    output logic             false_start,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TIMING,
        HOLD
    } state_t;

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] MAXM1 = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] count;
    logic             sat;
    logic             resp_e;
    logic             do_fs;
    logic             do_valid;
    logic             clr;
    logic             inc;

`ifdef REACTION_TIMER_RESP_SYNC_EN
    logic [1:0] resp_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sync <= 2'b00;
        end else begin
            resp_sync <= {resp_sync[0], resp};
        end
    end

    assign resp_e = resp_sync[1];
`else
    assign resp_e = resp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A response in ARMED is a false start even if start arrives with it.
    always_comb begin
        state_nx = state;
        do_fs    = 1'b0;
        do_valid = 1'b0;
        clr      = 1'b0;
        inc      = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                if (resp_e) begin
                    state_nx = HOLD;
                    do_fs    = 1'b1;
                end else if (start) begin
                    state_nx = TIMING;
                    clr      = 1'b1;
                end
            end
            TIMING: begin
                if (resp_e) begin
                    state_nx = HOLD;
                    do_valid = 1'b1;
                end else if (tick) begin
                    inc = 1'b1;
                end
            end
            HOLD: begin
                if (!resp_e) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            sat         <= 1'b0;
            elapsed     <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
            false_start <= 1'b0;
        end else begin
            valid       <= do_valid;
            false_start <= do_fs;
            if (clr) begin
                count <= '0;
                sat   <= 1'b0;
            end else if (inc && !sat) begin
                count <= count + 1'b1;
                sat   <= (count == MAXM1);
            end
            if (do_valid) begin
                elapsed  <= count;
                overflow <= sat;
            end
        end
    end

    assign busy = (state == ARMED) || (state == TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Directed testbench for reaction_timer (default build, resp used directly).
module tb_reaction_timer;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        start;
    logic        tick;
    logic        resp;
    logic [13:0] elapsed;
    logic        valid;
    logic        overflow;
    logic        false_start;
    logic        busy;
    logic [3:0]  s_elapsed;
    logic        s_valid;
    logic        s_overflow;
    logic        s_false_start;
    logic        s_busy;

    int passed = 0;
    int total  = 0;

    reaction_timer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .start       (start),
        .tick        (tick),
        .resp        (resp),
        .elapsed     (elapsed),
        .valid       (valid),
        .overflow    (overflow),
        .false_start (false_start),
        .busy        (busy)
    );

    reaction_timer #(.WIDTH(4)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .start       (start),
        .tick        (tick),
        .resp        (resp),
        .elapsed     (s_elapsed),
        .valid       (s_valid),
        .overflow    (s_overflow),
        .false_start (s_false_start),
        .busy        (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        arm   = 1'b0;
        start = 1'b0;
        tick  = 1'b0;
        resp  = 1'b0;
        #3;
        total++;
        if ({elapsed, valid, overflow, false_start, busy} !== 18'd0)
            $display("FAIL reset_outputs got %h want 0",
                     {elapsed, valid, overflow, false_start, busy});
        else passed++;
        #9 rst_n = 1'b1;
        cyc();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_normal();
        int extra_valid;
        pulse_arm();
        total++;
        if (busy !== 1'b1) $display("FAIL normal_armed_busy got %b want 1", busy);
        else passed++;
        cyc();
        cyc();
        pulse_start();
        total++;
        if (busy !== 1'b1) $display("FAIL normal_timing_busy got %b want 1", busy);
        else passed++;
        for (int i = 0; i < 250; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i == 100) begin
                start = 1'b1;
                arm   = 1'b1;
            end
            cyc();
            start = 1'b0;
            arm   = 1'b0;
            cyc();
            cyc();
        end
        resp = 1'b1;
        total++;
        if (valid !== 1'b0) $display("FAIL normal_pre_valid got %b want 0", valid);
        else passed++;
        cyc();
        total++;
        if (valid !== 1'b1 || elapsed !== 14'd250 || overflow !== 1'b0)
            $display("FAIL normal_result valid=%b elapsed=%0d ovf=%b want 1/250/0",
                     valid, elapsed, overflow);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL normal_busy_fall got %b want 0", busy);
        else passed++;
        extra_valid = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (valid || false_start || busy) extra_valid++;
        end
        total++;
        if (extra_valid !== 0)
            $display("FAIL normal_hold_quiet got %0d want 0", extra_valid);
        else passed++;
        resp = 1'b0;
        cyc();
        pulse_arm();
        total++;
        if (busy !== 1'b1) $display("FAIL normal_back_idle got %b want 1", busy);
        else passed++;
    endtask

    task automatic test_false_start();
        // trial already armed by previous test
        resp = 1'b1;
        cyc();
        total++;
        if (false_start !== 1'b1 || valid !== 1'b0 || elapsed !== 14'd250)
            $display("FAIL fs_pulse fs=%b valid=%b elapsed=%0d want 1/0/250",
                     false_start, valid, elapsed);
        else passed++;
        pulse_start();
        total++;
        if (false_start !== 1'b0 || busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL fs_single fs=%b busy=%b valid=%b want 0/0/0",
                     false_start, busy, valid);
        else passed++;
        pulse_arm();
        total++;
        if (busy !== 1'b0) $display("FAIL fs_hold_arm got %b want 0", busy);
        else passed++;
        resp = 1'b0;
        cyc();
        pulse_arm();
        total++;
        if (busy !== 1'b1) $display("FAIL fs_release_idle got %b want 1", busy);
        else passed++;
        start = 1'b1;
        resp  = 1'b1;
        cyc();
        start = 1'b0;
        total++;
        if (false_start !== 1'b1 || valid !== 1'b0)
            $display("FAIL fs_start_resp fs=%b valid=%b want 1/0", false_start, valid);
        else passed++;
        resp = 1'b0;
        cyc();
    endtask

    task automatic test_overflow();
        pulse_arm();
        pulse_start();
        tick = 1'b1;
        repeat (20) cyc();
        tick = 1'b0;
        resp = 1'b1;
        cyc();
        total++;
        if (s_valid !== 1'b1 || s_elapsed !== 4'd15 || s_overflow !== 1'b1)
            $display("FAIL ovf_small valid=%b elapsed=%0d ovf=%b want 1/15/1",
                     s_valid, s_elapsed, s_overflow);
        else passed++;
        total++;
        if (elapsed !== 14'd20 || overflow !== 1'b0)
            $display("FAIL ovf_wide elapsed=%0d ovf=%b want 20/0", elapsed, overflow);
        else passed++;
        resp = 1'b0;
        cyc();
        pulse_arm();
        pulse_start();
        tick = 1'b1;
        repeat (5) cyc();
        tick = 1'b0;
        resp = 1'b1;
        cyc();
        total++;
        if (s_valid !== 1'b1 || s_elapsed !== 4'd5 || s_overflow !== 1'b0)
            $display("FAIL ovf_next valid=%b elapsed=%0d ovf=%b want 1/5/0",
                     s_valid, s_elapsed, s_overflow);
        else passed++;
        resp = 1'b0;
        cyc();
    endtask

    task automatic test_coincident();
        pulse_arm();
        start = 1'b1;
        tick  = 1'b1;
        cyc();
        start = 1'b0;
        repeat (7) cyc();
        resp = 1'b1;
        cyc();
        tick = 1'b0;
        total++;
        if (valid !== 1'b1 || elapsed !== 14'd7)
            $display("FAIL coincident_ticks valid=%b elapsed=%0d want 1/7", valid, elapsed);
        else passed++;
        resp = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({elapsed, valid, overflow, false_start, busy} !== 18'd0)
            $display("FAIL reset_mid got %h want 0",
                     {elapsed, valid, overflow, false_start, busy});
        else passed++;
        #3 rst_n = 1'b1;
        cyc();
        pulse_start();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored busy=%b want 0", busy);
        else passed++;
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        resp = 1'b1;
        cyc();
        total++;
        if (valid !== 1'b0 || elapsed !== 14'd0)
            $display("FAIL reset_no_result valid=%b elapsed=%0d want 0/0", valid, elapsed);
        else passed++;
        resp = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_false_start();
        test_overflow();
        test_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
